// File: rtl/frame_checker.sv
// frame_checker: rebuilds the 4-word {zero, A, B, A+B} frames carried on a
// time-multiplexed stream, checks the sum and the phase order, and presents
// each completed frame with error pulses, a lock flag and saturating counters.
// Optional feature macro: FRAME_CHECK_ACCUM_EN adds a saturating Total of
// the sums of error-free frames.
//
// Stream handshake: there is none. Data_in/Phase are treated as valid on
// every rising edge (no valid, no ready, no backpressure). Frame_valid is a
// one-cycle strobe qualifying Frame_A/Frame_B/Frame_Sum and Sum_err.
module frame_checker #(
  parameter int OPND_W = 8,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Data_in,
  input  logic [1:0]        Phase,
  output logic [OPND_W-1:0] Frame_A,
  output logic [OPND_W-1:0] Frame_B,
  output logic [DATA_W-1:0] Frame_Sum,
  output logic              Frame_valid,
  output logic              Sum_err,
  output logic              Seq_err,
  output logic              Locked,
  output logic [CNT_W-1:0]  Frame_count,
  output logic [CNT_W-1:0]  Err_count,
`ifdef FRAME_CHECK_ACCUM_EN
  output logic [DATA_W+7:0] Total,
`endif
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    GOT_Z = 2'd1,
    GOT_A = 2'd2,
    GOT_B = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [OPND_W-1:0] a_q, a_d, b_q, b_d;
  logic [OPND_W-1:0] frame_a_q, frame_a_d, frame_b_q, frame_b_d;
  logic [DATA_W-1:0] frame_sum_q, frame_sum_d;
  logic              frame_valid_q, frame_valid_d;
  logic              sum_err_q, sum_err_d;
  logic              seq_err_q, seq_err_d;
  logic              locked_q, locked_d;
  logic [CNT_W-1:0]  frame_count_q, frame_count_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;

  // Decoded events for the current sample
  logic              data_zero, hi_nz;
  logic              seq_ev, cap_a, cap_b, done;
  logic [OPND_W:0]   sum_w;
  logic [DATA_W-1:0] sum_ext;

  assign data_zero = (Data_in == '0);
  // A/B words may only use the low OPND_W bits
  assign hi_nz     = |(Data_in >> OPND_W);

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= WAIT;
    else       state_q <= state_d;
  end

  // Next-state: a clean zero word always restarts a frame
  always_comb begin
    state_d = state_q;
    if (Phase == 2'b00) begin
      state_d = data_zero ? GOT_Z : WAIT;
    end else begin
      case (state_q)
        WAIT:    state_d = WAIT;
        GOT_Z:   state_d = (Phase == 2'b01 && !hi_nz) ? GOT_A : WAIT;
        GOT_A:   state_d = (Phase == 2'b10 && !hi_nz) ? GOT_B : WAIT;
        GOT_B:   state_d = WAIT;
        default: state_d = WAIT;
      endcase
    end
  end

  // FSM outputs: capture strobes, frame completion and order violations
  always_comb begin
    seq_ev = 1'b0;
    cap_a  = 1'b0;
    cap_b  = 1'b0;
    done   = 1'b0;
    if (Phase == 2'b00) begin
      seq_ev = !data_zero || (state_q != WAIT);
    end else begin
      case (state_q)
        WAIT:    seq_ev = locked_q;  // unlocked: hunting silently
        GOT_Z:   if (Phase == 2'b01 && !hi_nz) cap_a = 1'b1; else seq_ev = 1'b1;
        GOT_A:   if (Phase == 2'b10 && !hi_nz) cap_b = 1'b1; else seq_ev = 1'b1;
        GOT_B:   if (Phase == 2'b11) done = 1'b1; else seq_ev = 1'b1;
        default: seq_ev = 1'b1;
      endcase
    end
  end

  // Datapath next values: operand capture, frame registers, flags, counters
  always_comb begin
    sum_w         = {1'b0, a_q} + {1'b0, b_q};
    sum_ext       = '0;
    sum_ext[OPND_W:0] = sum_w;
    a_d           = cap_a ? Data_in[OPND_W-1:0] : a_q;
    b_d           = cap_b ? Data_in[OPND_W-1:0] : b_q;
    frame_a_d     = done ? a_q : frame_a_q;
    frame_b_d     = done ? b_q : frame_b_q;
    frame_sum_d   = done ? Data_in : frame_sum_q;
    frame_valid_d = done;
    sum_err_d     = done && (Data_in != sum_ext);
    seq_err_d     = seq_ev;
    locked_d      = locked_q;
    if (done)        locked_d = 1'b1;
    else if (seq_ev) locked_d = 1'b0;
    frame_count_d = frame_count_q;
    if (done && frame_count_q != '1) frame_count_d = frame_count_q + CNT_W'(1);
    err_count_d   = err_count_q;
    if ((seq_ev || sum_err_d) && err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
  end

  // Datapath registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_q           <= '0;
      b_q           <= '0;
      frame_a_q     <= '0;
      frame_b_q     <= '0;
      frame_sum_q   <= '0;
      frame_valid_q <= 1'b0;
      sum_err_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      locked_q      <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      a_q           <= a_d;
      b_q           <= b_d;
      frame_a_q     <= frame_a_d;
      frame_b_q     <= frame_b_d;
      frame_sum_q   <= frame_sum_d;
      frame_valid_q <= frame_valid_d;
      sum_err_q     <= sum_err_d;
      seq_err_q     <= seq_err_d;
      locked_q      <= locked_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
    end
  end

`ifdef FRAME_CHECK_ACCUM_EN
  logic [DATA_W+7:0] total_q, total_d;
  logic [DATA_W+8:0] total_sum;

  // Accumulate sums of good frames, updating alongside Frame_valid
  always_comb begin
    total_sum = {1'b0, total_q} + {9'd0, Data_in};
    total_d   = total_q;
    if (done && !sum_err_d) total_d = total_sum[DATA_W+8] ? '1 : total_sum[DATA_W+7:0];
  end

  // Accumulator register
  always_ff @(posedge Clock) begin
    if (Reset) total_q <= '0;
    else       total_q <= total_d;
  end

  assign Total = total_q;
`endif

  assign Frame_A     = frame_a_q;
  assign Frame_B     = frame_b_q;
  assign Frame_Sum   = frame_sum_q;
  assign Frame_valid = frame_valid_q;
  assign Sum_err     = sum_err_q;
  assign Seq_err     = seq_err_q;
  assign Locked      = locked_q;
  assign Frame_count = frame_count_q;
  assign Err_count   = err_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_frame_checker.sv
// Bench for frame_checker: table of stream words with expected pulses and
// lock flag, expected frame/counter values pushed to a queue per word and
// compared one cycle later, plus hand-written saturation/accumulator runs.
module tb_frame_checker;

  logic        Clock;
  logic        Reset;
  logic [15:0] Data_in;
  logic [1:0]  Phase;
  logic [7:0]  Frame_A, Frame_B;
  logic [15:0] Frame_Sum;
  logic        Frame_valid, Sum_err, Seq_err, Locked;
  logic [7:0]  Frame_count, Err_count;
  logic [1:0]  state_dbg;
`ifdef FRAME_CHECK_ACCUM_EN
  logic [23:0] Total;
`endif

  frame_checker dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Data_in     (Data_in),
    .Phase       (Phase),
    .Frame_A     (Frame_A),
    .Frame_B     (Frame_B),
    .Frame_Sum   (Frame_Sum),
    .Frame_valid (Frame_valid),
    .Sum_err     (Sum_err),
    .Seq_err     (Seq_err),
    .Locked      (Locked),
    .Frame_count (Frame_count),
    .Err_count   (Err_count),
`ifdef FRAME_CHECK_ACCUM_EN
    .Total       (Total),
`endif
    .state_dbg   (state_dbg)
  );

  // Clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Driver: apply one word and let the sampling edge pass
  task automatic cyc(input logic r, input logic [1:0] ph, input logic [15:0] d);
    Reset   = r;
    Phase   = ph;
    Data_in = d;
    @(posedge Clock);
    #1;
  endtask

  task automatic frame(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s);
    cyc(1'b0, 2'b00, 16'h0000);
    cyc(1'b0, 2'b01, a);
    cyc(1'b0, 2'b10, b);
    cyc(1'b0, 2'b11, s);
  endtask

  typedef struct {
    logic        r;
    logic [1:0]  ph;
    logic [15:0] d;
    logic        v, se, qe, lk;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [1:0] ph, input logic [15:0] d,
                     input logic v, input logic se, input logic qe, input logic lk);
    vec_t t;
    t.r = r; t.ph = ph; t.d = d; t.v = v; t.se = se; t.qe = qe; t.lk = lk;
    tbl.push_back(t);
  endtask

  // Scoreboard: {v,se,qe,lk,A,B,Sum,Frame_count,Err_count}
  localparam int EXP_W = 52;
  logic [EXP_W-1:0] exp_q[$];

  initial begin
    logic [7:0]  pa, pb, m_a, m_b, m_fc, m_ec;
    logic [15:0] m_sum;
    logic [EXP_W-1:0] e;
    Reset = 1'b1; Phase = 2'b00; Data_in = 16'h0;
    pa = 0; pb = 0; m_a = 0; m_b = 0; m_fc = 0; m_ec = 0; m_sum = 0;

    //  r    ph     data      v  se qe lk
    add(1, 2'b00, 16'h0000, 0, 0, 0, 0);
    // good frame
    add(0, 2'b00, 16'h0000, 0, 0, 0, 0);
    add(0, 2'b01, 16'h0012, 0, 0, 0, 0);
    add(0, 2'b10, 16'h0034, 0, 0, 0, 0);
    add(0, 2'b11, 16'h0046, 1, 0, 0, 1);
    // bad sum, stays locked
    add(0, 2'b00, 16'h0000, 0, 0, 0, 1);
    add(0, 2'b01, 16'h0005, 0, 0, 0, 1);
    add(0, 2'b10, 16'h0003, 0, 0, 0, 1);
    add(0, 2'b11, 16'h0009, 1, 1, 0, 1);
    // 00,01,11 -> order error, unlock; then relock
    add(0, 2'b00, 16'h0000, 0, 0, 0, 1);
    add(0, 2'b01, 16'h0011, 0, 0, 0, 1);
    add(0, 2'b11, 16'h0022, 0, 0, 1, 0);
    add(0, 2'b00, 16'h0000, 0, 0, 0, 0);
    add(0, 2'b01, 16'h0020, 0, 0, 0, 0);
    add(0, 2'b10, 16'h0030, 0, 0, 0, 0);
    add(0, 2'b11, 16'h0050, 1, 0, 0, 1);
    // carry into bit 8
    add(0, 2'b00, 16'h0000, 0, 0, 0, 1);
    add(0, 2'b01, 16'h00FF, 0, 0, 0, 1);
    add(0, 2'b10, 16'h00FF, 0, 0, 0, 1);
    add(0, 2'b11, 16'h01FE, 1, 0, 0, 1);
    // reset mid-frame, stray 11 ignored while unlocked
    add(0, 2'b00, 16'h0000, 0, 0, 0, 1);
    add(0, 2'b01, 16'h0007, 0, 0, 0, 1);
    add(0, 2'b10, 16'h0008, 0, 0, 0, 1);
    add(1, 2'b11, 16'h000F, 0, 0, 0, 0);
    add(0, 2'b11, 16'h000F, 0, 0, 0, 0);
    // unlocked hunting, then framing error on nonzero phase-00 word
    add(0, 2'b01, 16'h0005, 0, 0, 0, 0);
    add(0, 2'b00, 16'h0001, 0, 0, 1, 0);
    // A with bits above the operand width
    add(0, 2'b00, 16'h0000, 0, 0, 0, 0);
    add(0, 2'b01, 16'h0105, 0, 0, 1, 0);
    // lock, then a non-00 word while locked in WAIT
    add(0, 2'b00, 16'h0000, 0, 0, 0, 0);
    add(0, 2'b01, 16'h0001, 0, 0, 0, 0);
    add(0, 2'b10, 16'h0002, 0, 0, 0, 0);
    add(0, 2'b11, 16'h0003, 1, 0, 0, 1);
    add(0, 2'b10, 16'h0000, 0, 0, 1, 0);
    // repeated zero word restarts the frame with an order error
    add(0, 2'b00, 16'h0000, 0, 0, 0, 0);
    add(0, 2'b00, 16'h0000, 0, 0, 1, 0);
    add(0, 2'b01, 16'h0004, 0, 0, 0, 0);
    add(0, 2'b10, 16'h0005, 0, 0, 0, 0);
    add(0, 2'b11, 16'h0009, 1, 0, 0, 1);
    // B with bits above the operand width
    add(0, 2'b00, 16'h0000, 0, 0, 0, 1);
    add(0, 2'b01, 16'h0001, 0, 0, 0, 1);
    add(0, 2'b10, 16'h0200, 0, 0, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].r) begin
        pa = 0; pb = 0; m_a = 0; m_b = 0; m_sum = 0; m_fc = 0; m_ec = 0;
      end else begin
        if (tbl[i].ph == 2'b01) pa = tbl[i].d[7:0];
        if (tbl[i].ph == 2'b10) pb = tbl[i].d[7:0];
        if (tbl[i].v) begin
          m_a = pa; m_b = pb; m_sum = tbl[i].d;
          if (m_fc != 8'hFF) m_fc = m_fc + 8'd1;
        end
        if ((tbl[i].se || tbl[i].qe) && m_ec != 8'hFF) m_ec = m_ec + 8'd1;
      end
      exp_q.push_back({tbl[i].v, tbl[i].se, tbl[i].qe, tbl[i].lk,
                       m_a, m_b, m_sum, m_fc, m_ec});
      cyc(tbl[i].r, tbl[i].ph, tbl[i].d);
      e = exp_q.pop_front();
      chk($sformatf("v%0d Frame_valid", i), 32'(Frame_valid), 32'(e[51]));
      chk($sformatf("v%0d Sum_err", i),     32'(Sum_err),     32'(e[50]));
      chk($sformatf("v%0d Seq_err", i),     32'(Seq_err),     32'(e[49]));
      chk($sformatf("v%0d Locked", i),      32'(Locked),      32'(e[48]));
      chk($sformatf("v%0d Frame_A", i),     32'(Frame_A),     32'(e[47:40]));
      chk($sformatf("v%0d Frame_B", i),     32'(Frame_B),     32'(e[39:32]));
      chk($sformatf("v%0d Frame_Sum", i),   32'(Frame_Sum),   32'(e[31:16]));
      chk($sformatf("v%0d Frame_count", i), 32'(Frame_count), 32'(e[15:8]));
      chk($sformatf("v%0d Err_count", i),   32'(Err_count),   32'(e[7:0]));
      if (tbl[i].r) chk($sformatf("v%0d state_dbg", i), 32'(state_dbg), 32'd0);
    end

`ifdef FRAME_CHECK_ACCUM_EN
    // Accumulator: three good 0x46 frames, then a bad one
    cyc(1'b1, 2'b00, 16'h0000);
    chk("total_reset", 32'(Total), 32'h0);
    for (int k = 0; k < 3; k++) frame(16'h0012, 16'h0034, 16'h0046);
    chk("total_three", 32'(Total), 32'hD2);
    frame(16'h0005, 16'h0003, 16'h0009);
    chk("total_bad_sum", 32'(Sum_err), 32'd1);
    chk("total_hold", 32'(Total), 32'hD2);
`endif

    // Counter saturation: 300 bad-sum frames from reset
    cyc(1'b1, 2'b00, 16'h0000);
    for (int k = 1; k <= 300; k++) begin
      frame(16'h0005, 16'h0003, 16'h0009);
      if (k == 254) begin
        chk("sat_ec_254", 32'(Err_count),   32'hFE);
        chk("sat_fc_254", 32'(Frame_count), 32'hFE);
      end
      if (k == 255) chk("sat_ec_255", 32'(Err_count), 32'hFF);
    end
    chk("sat_sum_err", 32'(Sum_err),     32'd1);
    chk("sat_ec_300",  32'(Err_count),   32'hFF);
    chk("sat_fc_300",  32'(Frame_count), 32'hFF);
    chk("sat_locked",  32'(Locked),      32'd1);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
